// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between the writeback/multiplier side and wb_port_arbiter.
// Multiplier handshake: a result transfers on a rising edge where mul_valid && mul_ready are both 1.
// mul_ready depends only on registered state. There is no pipeline back-pressure.
interface wb_port_arbiter_if;
  logic        pipe_we;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        mul_valid;
  logic        mul_ready;
  logic [4:0]  mul_waddr;
  logic [31:0] mul_wdata;
  logic        issue_valid;
  logic [4:0]  issue_waddr;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic        hazard1;
  logic        hazard2;
  logic        hazard_w;
  logic        stall_req;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        err;

  modport master (
    output pipe_we, pipe_waddr, pipe_wdata,
    output mul_valid, mul_waddr, mul_wdata,
    output issue_valid, issue_waddr, raddr1, raddr2,
    input  mul_ready, hazard1, hazard2, hazard_w, stall_req,
    input  rf_we, rf_waddr, rf_wdata, err
  );

  modport slave (
    input  pipe_we, pipe_waddr, pipe_wdata,
    input  mul_valid, mul_waddr, mul_wdata,
    input  issue_valid, issue_waddr, raddr1, raddr2,
    output mul_ready, hazard1, hazard2, hazard_w, stall_req,
    output rf_we, rf_waddr, rf_wdata, err
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter: the pipeline always wins, and multiplier results wait in a FIFO.
// It also keeps a busy scoreboard and a starvation guard. Optional checker: WBARB_PROTOCOL_CHECK_EN.
module wb_port_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              rst,
  wb_port_arbiter_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [36:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [3:0]    r_starve;
  logic [31:0]   r_busy;
  logic          r_rf_we;
  logic          r_from_fifo;
  logic [4:0]    r_rf_waddr;
  logic [31:0]   r_rf_wdata;

  logic          w_full;
  logic          w_empty;
  logic          w_pipe_valid;
  logic          w_push;
  logic          w_pop;
  logic [4:0]    w_head_waddr;
  logic [31:0]   w_head_wdata;
  logic [31:0]   w_set_mask;
  logic [31:0]   w_clr_mask;

  assign w_full       = (r_count == CW'(FIFO_DEPTH));
  assign w_empty      = (r_count == '0);
  assign w_pipe_valid = bus.pipe_we && (bus.pipe_waddr != 5'd0);
  assign w_push       = bus.mul_valid && !w_full;
  assign w_pop        = !w_empty && !w_pipe_valid;
  assign w_head_waddr = r_mem[r_rd_ptr][36:32];
  assign w_head_wdata = r_mem[r_rd_ptr][31:0];

  // The set mask is applied after the clear mask, so an issue wins over a retiring write to the same register.
  assign w_set_mask = (bus.issue_valid && (bus.issue_waddr != 5'd0)) ? (32'd1 << bus.issue_waddr) : 32'd0;
  assign w_clr_mask = (r_rf_we && r_from_fifo) ? (32'd1 << r_rf_waddr) : 32'd0;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {bus.mul_waddr, bus.mul_wdata};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_starve    <= 4'd0;
      r_busy      <= 32'd0;
      r_rf_we     <= 1'b0;
      r_from_fifo <= 1'b0;
      r_rf_waddr  <= 5'd0;
      r_rf_wdata  <= 32'd0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase

      if (w_empty || w_pop)
        r_starve <= 4'd0;
      else if (w_pipe_valid && (r_starve != 4'(STARVE_LIMIT)))
        r_starve <= r_starve + 4'd1;

      r_busy <= ((r_busy & ~w_clr_mask) | w_set_mask) & 32'hFFFF_FFFE;

      if (w_pipe_valid) begin
        r_rf_we     <= 1'b1;
        r_from_fifo <= 1'b0;
        r_rf_waddr  <= bus.pipe_waddr;
        r_rf_wdata  <= bus.pipe_wdata;
      end else if (w_pop && (w_head_waddr != 5'd0)) begin
        r_rf_we     <= 1'b1;
        r_from_fifo <= 1'b1;
        r_rf_waddr  <= w_head_waddr;
        r_rf_wdata  <= w_head_wdata;
      end else begin
        r_rf_we     <= 1'b0;
        r_from_fifo <= 1'b0;
      end
    end
  end

  assign bus.mul_ready = !w_full;
  assign bus.stall_req = (r_starve == 4'(STARVE_LIMIT));
  assign bus.hazard1   = r_busy[bus.raddr1];
  assign bus.hazard2   = r_busy[bus.raddr2];
  assign bus.hazard_w  = r_busy[bus.issue_waddr];
  assign bus.rf_we     = r_rf_we;
  assign bus.rf_waddr  = r_rf_waddr;
  assign bus.rf_wdata  = r_rf_wdata;

`ifdef WBARB_PROTOCOL_CHECK_EN
  logic r_err;
  logic w_err_evt;

  assign w_err_evt = (bus.issue_valid && (bus.issue_waddr != 5'd0) && r_busy[bus.issue_waddr])
                   || (bus.mul_valid && (bus.mul_waddr != 5'd0) && !r_busy[bus.mul_waddr])
                   || (w_pipe_valid && r_busy[bus.pipe_waddr]);

  always_ff @(posedge clk) begin
    if (!rst)           r_err <= 1'b0;
    else if (w_err_evt) r_err <= 1'b1;
  end

  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with hand-computed expectations.
module tb_wb_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic exp_err = 1'b0;

  wb_port_arbiter_if bus ();

  wb_port_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    bus.pipe_we     = 1'b0;
    bus.pipe_waddr  = 5'd0;
    bus.pipe_wdata  = 32'd0;
    bus.mul_valid   = 1'b0;
    bus.mul_waddr   = 5'd0;
    bus.mul_wdata   = 32'd0;
    bus.issue_valid = 1'b0;
    bus.issue_waddr = 5'd0;
    bus.raddr1      = 5'd0;
    bus.raddr2      = 5'd0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rf(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_we"}, {31'd0, bus.rf_we}, {31'd0, we});
    chk({tag, "_waddr"}, {27'd0, bus.rf_waddr}, {27'd0, a});
    chk({tag, "_wdata"}, bus.rf_wdata, d);
  endtask

  initial begin
    // Reset
    idle();
    tick();
    tick();
    chk_rf("rst", 1'b0, 5'd0, 32'd0);
    chk("rst_mul_ready", {31'd0, bus.mul_ready}, 32'd1);
    chk("rst_stall", {31'd0, bus.stall_req}, 32'd0);
    chk("rst_err", {31'd0, bus.err}, 32'd0);
    rst = 1'b1;
    tick();

    // Pipeline write only
    bus.pipe_we = 1'b1; bus.pipe_waddr = 5'd5; bus.pipe_wdata = 32'h1234;
    tick();
    chk_rf("pipe", 1'b1, 5'd5, 32'h1234);
    bus.pipe_waddr = 5'd0; bus.pipe_wdata = 32'h5555;
    tick();
    chk_rf("pipe_r0", 1'b0, 5'd5, 32'h1234);
    idle();

    // Multiplier path through the FIFO
    bus.issue_valid = 1'b1; bus.issue_waddr = 5'd7;
    tick();
    idle(); bus.raddr1 = 5'd7; bus.raddr2 = 5'd7; settle();
    chk("mul_hazard1_set", {31'd0, bus.hazard1}, 32'd1);
    chk("mul_hazard2_set", {31'd0, bus.hazard2}, 32'd1);
    tick();
    bus.issue_waddr = 5'd7; settle();
    chk("mul_hazard_w", {31'd0, bus.hazard_w}, 32'd1);
    tick();
    bus.issue_waddr = 5'd0;
    bus.mul_valid = 1'b1; bus.mul_waddr = 5'd7; bus.mul_wdata = 32'hCAFE;
    tick();
    bus.mul_valid = 1'b0; settle();
    chk_rf("mul_c4", 1'b0, 5'd5, 32'h1234);
    chk("mul_ready_c4", {31'd0, bus.mul_ready}, 32'd1);
    chk("mul_hazard_c4", {31'd0, bus.hazard1}, 32'd1);
    tick();
    chk_rf("mul_c5", 1'b1, 5'd7, 32'hCAFE);
    chk("mul_hazard_c5", {31'd0, bus.hazard1}, 32'd1);
    tick();
    chk("mul_hazard_c6", {31'd0, bus.hazard1}, 32'd0);
    chk("mul_we_c6", {31'd0, bus.rf_we}, 32'd0);

    // Collision: the pipeline wins, and the FIFO head follows
    idle();
    bus.issue_valid = 1'b1; bus.issue_waddr = 5'd9;
    tick();
    idle(); bus.mul_valid = 1'b1; bus.mul_waddr = 5'd9; bus.mul_wdata = 32'h99;
    tick();
    idle(); bus.pipe_we = 1'b1; bus.pipe_waddr = 5'd3; bus.pipe_wdata = 32'h33;
    tick();
    idle();
    chk_rf("col_pipe", 1'b1, 5'd3, 32'h33);
    tick();
    chk_rf("col_fifo", 1'b1, 5'd9, 32'h99);
    chk("col_stall", {31'd0, bus.stall_req}, 32'd0);
    tick();
    bus.raddr1 = 5'd9; settle();
    chk("col_hazard_clr", {31'd0, bus.hazard1}, 32'd0);
    chk("col_we_idle", {31'd0, bus.rf_we}, 32'd0);

    // Full FIFO and starvation guard
    idle();
    bus.issue_valid = 1'b1; bus.issue_waddr = 5'd10;
    tick();
    bus.issue_waddr = 5'd11;
    tick();
    idle();
    bus.pipe_we = 1'b1; bus.pipe_waddr = 5'd1; bus.pipe_wdata = 32'h1;
    bus.mul_valid = 1'b1; bus.mul_waddr = 5'd10; bus.mul_wdata = 32'hA0;
    tick();
    chk("full_ready_p1", {31'd0, bus.mul_ready}, 32'd1);
    bus.mul_waddr = 5'd11; bus.mul_wdata = 32'hB0;
    tick();
    bus.mul_valid = 1'b0;
    chk("full_ready_p2", {31'd0, bus.mul_ready}, 32'd0);
    chk("full_stall_p2", {31'd0, bus.stall_req}, 32'd0);
    tick();
    tick();
    chk("full_stall_p4", {31'd0, bus.stall_req}, 32'd0);
    tick();
    chk("full_stall_p5", {31'd0, bus.stall_req}, 32'd1);
    chk_rf("full_pipe_p5", 1'b1, 5'd1, 32'h1);
    bus.pipe_we = 1'b0;
    tick();
    chk("full_stall_p6", {31'd0, bus.stall_req}, 32'd0);
    chk("full_ready_p6", {31'd0, bus.mul_ready}, 32'd1);
    chk_rf("full_pop_p6", 1'b1, 5'd10, 32'hA0);
    tick();
    chk_rf("full_pop_p7", 1'b1, 5'd11, 32'hB0);
    idle();

    // Same-cycle set and clear of r4: the set wins
    bus.issue_valid = 1'b1; bus.issue_waddr = 5'd4;
    tick();
    idle(); bus.mul_valid = 1'b1; bus.mul_waddr = 5'd4; bus.mul_wdata = 32'h44;
    tick();
    idle();
    tick();
    chk_rf("sc_write", 1'b1, 5'd4, 32'h44);
    bus.issue_valid = 1'b1; bus.issue_waddr = 5'd4;
`ifdef WBARB_PROTOCOL_CHECK_EN
    exp_err = 1'b1;
`endif
    tick();
    idle(); bus.raddr1 = 5'd4; settle();
    chk("sc_still_busy", {31'd0, bus.hazard1}, 32'd1);
    chk("sc_err", {31'd0, bus.err}, {31'd0, exp_err});
    bus.mul_valid = 1'b1; bus.mul_waddr = 5'd4; bus.mul_wdata = 32'h45;
    tick();
    bus.mul_valid = 1'b0;
    tick();
    chk_rf("sc_rewrite", 1'b1, 5'd4, 32'h45);
    tick();
    chk("sc_cleared", {31'd0, bus.hazard1}, 32'd0);

    // A FIFO entry addressed to r0 is dropped, and address/data hold
    idle();
    bus.mul_valid = 1'b1; bus.mul_waddr = 5'd0; bus.mul_wdata = 32'hDEAD;
    tick();
    idle();
    tick();
    chk_rf("r0_drop", 1'b0, 5'd4, 32'h45);
    chk("r0_ready", {31'd0, bus.mul_ready}, 32'd1);
    chk("err_sticky", {31'd0, bus.err}, {31'd0, exp_err});

    // Reset with two buffered entries and busy bits set
    bus.issue_valid = 1'b1; bus.issue_waddr = 5'd12;
    tick();
    bus.issue_waddr = 5'd13;
    tick();
    idle();
    bus.pipe_we = 1'b1; bus.pipe_waddr = 5'd2; bus.pipe_wdata = 32'h22;
    bus.mul_valid = 1'b1; bus.mul_waddr = 5'd12; bus.mul_wdata = 32'hC0;
    tick();
    bus.mul_waddr = 5'd13; bus.mul_wdata = 32'hD0;
    tick();
    bus.mul_valid = 1'b0;
    chk("pre_rst_full", {31'd0, bus.mul_ready}, 32'd0);
    idle();
    rst = 1'b0;
    tick();
    bus.raddr1 = 5'd12; bus.raddr2 = 5'd13; settle();
    chk_rf("mid_rst", 1'b0, 5'd0, 32'd0);
    chk("mid_rst_ready", {31'd0, bus.mul_ready}, 32'd1);
    chk("mid_rst_stall", {31'd0, bus.stall_req}, 32'd0);
    chk("mid_rst_err", {31'd0, bus.err}, 32'd0);
    chk("mid_rst_h1", {31'd0, bus.hazard1}, 32'd0);
    chk("mid_rst_h2", {31'd0, bus.hazard2}, 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_no_we", {31'd0, bus.rf_we}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
